// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: sequences phase increments into an NCO for stepped or
// chirped sweeps, keeps the NCO clocked until its pipeline has flushed, and
// tags the first and last output samples of each pass with a pipeline whose
// latency matches the NCO's.
module nco_sweep_ctrl #(
  parameter int APR = 32,
  parameter int DWW = 16,
  parameter int CNW = 16,
  parameter int LAT = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [APR-1:0] cfg_start,
  input  logic [APR-1:0] cfg_step,
  input  logic [CNW-1:0] cfg_count,
  input  logic [DWW-1:0] cfg_dwell,
  input  logic           cfg_loop,
  input  logic           abort,
  output logic           nco_clken,
  output logic [APR-1:0] nco_phi_inc,
  output logic           busy,
  output logic           done,
  output logic           tag_sop,
  output logic           tag_eop
);

  // Drain counter only has to reach LAT-1.
  localparam int DCW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Latched descriptor. The step count is stored as count-1 so that a
  // requested count of 0 collapses to a single step.
  logic [APR-1:0] r_start;
  logic [APR-1:0] r_step;
  logic [CNW-1:0] r_count_m1;
  logic [DWW-1:0] r_dwell;
  logic           r_loop;

  // Running sweep state.
  logic [APR-1:0] r_phi;
  logic [CNW-1:0] r_step_idx;
  logic [DWW-1:0] r_dwell_cnt;
  logic [DCW-1:0] r_drain_cnt;
  logic           r_done;

  // Tag pipeline, one bit per stage for each tag.
  logic [LAT-1:0] r_sop_pipe;
  logic [LAT-1:0] r_eop_pipe;

  logic           w_dwell_end;
  logic           w_last_step;
  logic           w_drain_end;
  logic           w_sop_in;
  logic           w_eop_in;
  logic           w_active;

  assign w_dwell_end = (r_dwell_cnt == '0);
  assign w_last_step = (r_step_idx == r_count_m1);
  assign w_drain_end = (r_drain_cnt == '0);
  assign w_active    = (r_state != ST_IDLE);

  assign cfg_ready   = (r_state == ST_IDLE);
  assign busy        = w_active;
  assign nco_clken   = w_active;
  assign nco_phi_inc = r_phi;
  assign done        = r_done;
  assign tag_sop     = nco_clken & r_sop_pipe[LAT-1];
  assign tag_eop     = nco_clken & r_eop_pipe[LAT-1];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and the tag values entering the pipeline this cycle.
  always_comb begin
    w_state_next = r_state;
    w_sop_in     = 1'b0;
    w_eop_in     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg_valid) begin
          w_state_next = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        // First cycle of a pass: step 0 with the dwell counter freshly loaded.
        w_sop_in = (r_step_idx == '0) && (r_dwell_cnt == r_dwell);
        // Abort turns the current cycle into the final one of the sweep.
        if (abort || (w_dwell_end && w_last_step && !r_loop)) begin
          w_eop_in     = 1'b1;
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_drain_end) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Descriptor capture and sweep datapath: phase, step index, dwell, drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_start     <= '0;
      r_step      <= '0;
      r_count_m1  <= '0;
      r_dwell     <= '0;
      r_loop      <= 1'b0;
      r_phi       <= '0;
      r_step_idx  <= '0;
      r_dwell_cnt <= '0;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cfg_valid) begin
            r_start     <= cfg_start;
            r_step      <= cfg_step;
            r_count_m1  <= (cfg_count == '0) ? '0 : (cfg_count - CNW'(1));
            r_dwell     <= cfg_dwell;
            r_loop      <= cfg_loop;
            r_phi       <= cfg_start;
            r_step_idx  <= '0;
            r_dwell_cnt <= cfg_dwell;
          end
        end
        ST_SWEEP: begin
          if (w_state_next == ST_DRAIN) begin
            // Phase is held through the drain.
            r_drain_cnt <= DCW'(LAT - 1);
          end else if (w_dwell_end) begin
            r_dwell_cnt <= r_dwell;
            if (w_last_step) begin
              // Looping: restart the pass from the initial increment.
              r_phi      <= r_start;
              r_step_idx <= '0;
            end else begin
              r_phi      <= r_phi + r_step;
              r_step_idx <= r_step_idx + CNW'(1);
            end
          end else begin
            r_dwell_cnt <= r_dwell_cnt - DWW'(1);
          end
        end
        ST_DRAIN: begin
          if (!w_drain_end) begin
            r_drain_cnt <= r_drain_cnt - DCW'(1);
          end
        end
        default: begin
          r_drain_cnt <= '0;
        end
      endcase
    end
  end

  // Done pulse in the first idle cycle after a completed drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DRAIN) && w_drain_end;
    end
  end

  // Tag pipeline stages: advance only while the NCO is clocked, cleared idle.
  generate
    for (genvar gi = 0; gi < LAT; gi++) begin : g_tag_pipe
      if (gi == 0) begin : g_head
        // Head stage takes the tags generated by the sequencer.
        always_ff @(posedge clk) begin
          if (reset || (r_state == ST_IDLE)) begin
            r_sop_pipe[0] <= 1'b0;
            r_eop_pipe[0] <= 1'b0;
          end else if (nco_clken) begin
            r_sop_pipe[0] <= w_sop_in;
            r_eop_pipe[0] <= w_eop_in;
          end
        end
      end else begin : g_body
        // Later stages copy the previous stage.
        always_ff @(posedge clk) begin
          if (reset || (r_state == ST_IDLE)) begin
            r_sop_pipe[gi] <= 1'b0;
            r_eop_pipe[gi] <= 1'b0;
          end else if (nco_clken) begin
            r_sop_pipe[gi] <= r_sop_pipe[gi-1];
            r_eop_pipe[gi] <= r_eop_pipe[gi-1];
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Scoreboard bench for nco_sweep_ctrl: stimulus pushes the expected per-cycle
// NCO drive/tag records, a monitor pops and compares whenever the DUT is active
// or pulses done, and also checks that records arrive on consecutive cycles.
module tb_nco_sweep_ctrl;

  localparam int APR = 32;
  localparam int DWW = 16;
  localparam int CNW = 16;
  localparam int LAT = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [APR-1:0] cfg_start;
  logic [APR-1:0] cfg_step;
  logic [CNW-1:0] cfg_count;
  logic [DWW-1:0] cfg_dwell;
  logic           cfg_loop;
  logic           abort;
  logic           nco_clken;
  logic [APR-1:0] nco_phi_inc;
  logic           busy;
  logic           done;
  logic           tag_sop;
  logic           tag_eop;

  nco_sweep_ctrl #(.APR(APR), .DWW(DWW), .CNW(CNW), .LAT(LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_start   (cfg_start),
    .cfg_step    (cfg_step),
    .cfg_count   (cfg_count),
    .cfg_dwell   (cfg_dwell),
    .cfg_loop    (cfg_loop),
    .abort       (abort),
    .nco_clken   (nco_clken),
    .nco_phi_inc (nco_phi_inc),
    .busy        (busy),
    .done        (done),
    .tag_sop     (tag_sop),
    .tag_eop     (tag_eop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] phi;
    bit          sop;
    bit          eop;
    bit          dn;
    bit          first;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   last_pop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: one expected record per active or done cycle.
  always @(negedge clk) begin
    if (nco_clken || done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output cyc=%0d clken=%0b done=%0b phi=%h sop=%0b eop=%0b",
                 cyc, nco_clken, done, nco_phi_inc, tag_sop, tag_eop);
      end else begin
        exp_t e;
        int   want_cyc;
        e = exp_q.pop_front();
        checks++;
        if ((nco_clken != !e.dn) || (busy != !e.dn) || (cfg_ready != e.dn) ||
            (done != e.dn) || (tag_sop != e.sop) || (tag_eop != e.eop) ||
            (!e.dn && (nco_phi_inc != e.phi))) begin
          errors++;
          $display("FAIL record cyc=%0d got clken=%0b busy=%0b rdy=%0b done=%0b phi=%h sop=%0b eop=%0b want clken=%0b done=%0b phi=%h sop=%0b eop=%0b",
                   cyc, nco_clken, busy, cfg_ready, done, nco_phi_inc, tag_sop, tag_eop,
                   !e.dn, e.dn, e.phi, e.sop, e.eop);
        end
        want_cyc = e.first ? acc_cyc : (last_pop + 1);
        checks++;
        if (cyc != want_cyc) begin
          errors++;
          $display("FAIL timing got_cycle=%0d want_cycle=%0d", cyc, want_cyc);
        end
        last_pop = cyc;
      end
    end
  end

  task automatic push_rec(input logic [31:0] phi, input bit sop, input bit eop,
                          input bit dn, input bit first);
    exp_t e;
    e.phi = phi; e.sop = sop; e.eop = eop; e.dn = dn; e.first = first;
    exp_q.push_back(e);
  endtask

  // Expected record stream of one sweep, straight from the descriptor.
  task automatic gen_sweep(input logic [31:0] start, input logic [31:0] step,
                           input int count, input int dwell, input int abort_idx,
                           input bit first_flag);
    logic [31:0] pa [64];
    bit          sa [64];
    bit          ea [64];
    int          cnt;
    int          plen;
    int          nsw;
    int          pos;
    bit          s;
    bit          t;
    cnt  = (count == 0) ? 1 : count;
    plen = cnt * (dwell + 1);
    nsw  = (abort_idx >= 0) ? abort_idx + 1 : plen;
    for (int i = 0; i < nsw; i++) begin
      pos   = i % plen;
      pa[i] = start + step * 32'(pos / (dwell + 1));
      sa[i] = (pos == 0);
      ea[i] = (i == nsw - 1);
    end
    for (int j = 0; j < nsw + LAT; j++) begin
      s = 1'b0;
      t = 1'b0;
      if (j >= LAT) begin
        s = sa[j-LAT];
        t = ea[j-LAT];
      end
      push_rec((j < nsw) ? pa[j] : pa[nsw-1], s, t, 1'b0, first_flag && (j == 0));
    end
    push_rec(32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic set_cfg(input logic [31:0] start, input logic [31:0] step,
                         input int count, input int dwell, input bit lp);
    cfg_start = start;
    cfg_step  = step;
    cfg_count = CNW'(count);
    cfg_dwell = DWW'(dwell);
    cfg_loop  = lp;
  endtask

  // Offer a descriptor for one edge; returns #1 after the accepting edge.
  task automatic issue_cfg(input logic [31:0] start, input logic [31:0] step,
                           input int count, input int dwell, input bit lp);
    $display("sweep start=%h step=%h count=%0d dwell=%0d loop=%0b", start, step, count, dwell, lp);
    @(posedge clk);
    #1;
    set_cfg(start, step, count, dwell, lp);
    cfg_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout left=%0d want=0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tbl [4];
    reset     = 1'b1;
    cfg_valid = 1'b0;
    abort     = 1'b0;
    set_cfg(32'h0, 32'h0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state.
    @(negedge clk);
    check1("rst_clken", 32'(nco_clken), 32'h0);
    check1("rst_phi", nco_phi_inc, 32'h0);
    check1("rst_busy", 32'(busy), 32'h0);
    check1("rst_done", 32'(done), 32'h0);
    check1("rst_tags", {30'h0, tag_sop, tag_eop}, 32'h0);
    check1("rst_ready", 32'(cfg_ready), 32'h1);

    // One-shot, hand-tabulated: 12 SWEEP cycles, 8 DRAIN, done at index 20.
    tbl[0] = 32'h01000000;
    tbl[1] = 32'h01100000;
    tbl[2] = 32'h01200000;
    tbl[3] = 32'h01300000;
    for (int j = 0; j < 20; j++)
      push_rec((j < 12) ? tbl[j/3] : tbl[3], j == 8, j == 19, 1'b0, j == 0);
    push_rec(32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    issue_cfg(32'h01000000, 32'h00100000, 4, 2, 1'b0);
    // Abort during DRAIN (index 15) must be ignored.
    repeat (15) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_empty();

    // Abort while idle is ignored.
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check1("idle_abort_busy", 32'(busy), 32'h0);

    // Wrap through zero, and a negative step.
    gen_sweep(32'hFFF00000, 32'h00100000, 2, 0, -1, 1'b1);
    issue_cfg(32'hFFF00000, 32'h00100000, 2, 0, 1'b0);
    wait_empty();
    gen_sweep(32'h00000000, 32'hFFF00000, 2, 0, -1, 1'b1);
    issue_cfg(32'h00000000, 32'hFFF00000, 2, 0, 1'b0);
    wait_empty();

    // Looping sweeps terminated by abort.
    gen_sweep(32'h20000000, 32'h01000000, 2, 0, 11, 1'b1);
    issue_cfg(32'h20000000, 32'h01000000, 2, 0, 1'b1);
    repeat (11) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_empty();
    gen_sweep(32'h30000000, 32'h00010000, 3, 1, 9, 1'b1);
    issue_cfg(32'h30000000, 32'h00010000, 3, 1, 1'b1);
    repeat (9) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_empty();

    // count=0 => one step of dwell+1 cycles; cfg offered while busy is ignored.
    gen_sweep(32'h12345678, 32'h00000001, 0, 3, -1, 1'b1);
    issue_cfg(32'h12345678, 32'h00000001, 0, 3, 1'b0);
    @(posedge clk);
    #1;
    set_cfg(32'hDEADBEEF, 32'h11111111, 5, 0, 1'b1);
    cfg_valid = 1'b1;
    @(negedge clk);
    check1("busy_sweep_ready", 32'(cfg_ready), 32'h0);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 cfg_valid = 1'b1;
    @(negedge clk);
    check1("busy_drain_ready", 32'(cfg_ready), 32'h0);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    wait_empty();

    // Reset mid-SWEEP: five active records, then everything cleared.
    push_rec(32'h100, 1'b0, 1'b0, 1'b0, 1'b1);
    push_rec(32'h100, 1'b0, 1'b0, 1'b0, 1'b0);
    push_rec(32'h110, 1'b0, 1'b0, 1'b0, 1'b0);
    push_rec(32'h110, 1'b0, 1'b0, 1'b0, 1'b0);
    push_rec(32'h120, 1'b0, 1'b0, 1'b0, 1'b0);
    issue_cfg(32'h100, 32'h10, 3, 1, 1'b0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    gen_sweep(32'h40000000, 32'h00000100, 2, 1, -1, 1'b1);
    $display("sweep start=40000000 step=00000100 count=2 dwell=1 loop=0 (after reset)");
    set_cfg(32'h40000000, 32'h00000100, 2, 1, 1'b0);
    cfg_valid = 1'b1;
    @(negedge clk);
    check1("rreset_clken", 32'(nco_clken), 32'h0);
    check1("rreset_busy", 32'(busy), 32'h0);
    check1("rreset_done", 32'(done), 32'h0);
    check1("rreset_tags", {30'h0, tag_sop, tag_eop}, 32'h0);
    check1("rreset_phi", nco_phi_inc, 32'h0);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    cfg_valid = 1'b0;
    wait_empty();

    // Back-to-back with cfg_valid held: second sweep follows the done cycle.
    gen_sweep(32'h50000000, 32'h00000020, 2, 1, -1, 1'b1);
    gen_sweep(32'h50000000, 32'h00000020, 2, 1, -1, 1'b0);
    $display("sweep start=50000000 step=00000020 count=2 dwell=1 loop=0 (x2 back-to-back)");
    @(posedge clk);
    #1;
    set_cfg(32'h50000000, 32'h00000020, 2, 1, 1'b0);
    cfg_valid = 1'b1;
    @(posedge clk);
    #1 acc_cyc = cyc;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) break;
    end
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    wait_empty();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
